prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//   Writes a program image into the CPU's 256x8 RAM over a byte-stream valid/ready input.
//   The CPU only reads program memory; this block is its writer.
//   Halts the CPU, checks a length/data/checksum frame, and writes each data byte to RAM.
//   On a good checksum it pulses cpu_run. While busy it owns the RAM port through mem_sel.
// PARAMETERS
//   BASE_ADDR    8'h00  RAM address of the first data byte
//   RUN_ON_DONE  1      1: pulse cpu_run after a good frame; 0: leave the CPU halted
//   TIMEOUT      255    maximum idle cycles between accepted bytes before error (1..255)
// PORTS
//   clk        in   1  system clock, rising-edge
//   rst        in   1  asynchronous, active-low reset
//   start      in   1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR
//   in_valid   in   1  stream byte valid
//   in_data    in   8  stream byte
//   in_ready   out  1  byte accepted on a cycle where in_valid & in_ready
//   mem_sel    out  1  1: RAM addr/data/wren are driven by this block (top-level mux)
//   ram_addr   out  8  RAM write address
//   ram_data   out  8  RAM write data
//   ram_wren   out  1  RAM write enable
//   cpu_halt   out  1  to stage.halt
//   cpu_run    out  1  to stage.run
//   busy       out  1  a load is in progress
//   done       out  1  sticky: last frame good
//   err        out  1  sticky: last frame bad or timed out
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; checksum, count and timer cleared.
//   Frame format: LEN (0 means 256 bytes), then LEN data bytes, then SUM.
//     SUM = 8-bit modulo-256 sum of the data bytes only.
//   States and transitions:
//     IDLE/DONE/ERR --start--> HALT.
//       Entering HALT clears done and err, and sets busy and mem_sel.
//     HALT: cpu_halt=1 for exactly 1 cycle -> LEN.
//     LEN: in_ready=1. On accept: cnt=LEN, addr=BASE_ADDR, sum=0 -> DATA.
//     DATA: in_ready=1. On accept: latch ram_data=in_data, sum+=in_data -> WR.
//     WR: in_ready=0, ram_wren=1 for exactly 1 cycle.
//       ram_addr and ram_data stay stable for the whole cycle, so either RAM clock edge captures them.
//       Then addr+=1 (wraps 8'hFF->8'h00) and cnt-=1. cnt==0 -> SUM, else -> DATA.
//     SUM: in_ready=1. On accept: equal -> RUN, else -> ERR.
//     RUN: cpu_run=RUN_ON_DONE for 1 cycle, mem_sel=0 -> DONE.
//     DONE: done=1, busy=0.  ERR: err=1, busy=0, mem_sel=0, CPU stays halted.
//   Throughput: at most one data byte every 2 cycles. LEN and SUM are accepted back-to-back.
//   Timeout: timer counts cycles in LEN/DATA/SUM without an accept.
//     Reaching TIMEOUT -> ERR. The timer reloads on every accept and on leaving WR.
//   Writes: ram_wren is never asserted outside WR.
//     Data already written in a failed frame is not rolled back.
//   Simultaneous start + in_valid in IDLE: start wins and the byte is not consumed (in_ready=0).
//   start while busy is ignored.
//   Reset mid-load: immediate return to IDLE.
//     ram_wren, cpu_halt and cpu_run drop asynchronously, and mem_sel releases the bus.
//   LEN=0 with BASE_ADDR=0: writes all 256 locations, ending at address 8'hFF.
// STRUCTURE
//   Shared package / header (cpu_defs):
//     loader state encoding (localparam, 4-bit: IDLE, HALT, LEN, DATA, WR, SUM, RUN, DONE, ERR).
//     RAM_AW=8, DW=8.
//   Sub-module ldr_timer: loadable down-counter with expire flag.
//     The rest is one FSM plus datapath registers (addr, cnt[8:0], sum).
// TESTING
//   1. Reset held low -> all outputs 0. Pulse start -> cpu_halt=1 for exactly 1 cycle, busy=1.
//   2. Frame 03,11,22,33,SUM=66 -> writes [00]=11,[01]=22,[02]=33, one ram_wren each.
//      Then cpu_run pulses once, done=1, err=0.
//   3. Same frame with SUM=67 -> same 3 writes, err=1, done=0, cpu_run never asserted.
//   4. BASE_ADDR=FE, frame 03,AA,BB,CC,SUM=31 -> addresses FE,FF,00 (wrap), done=1.
//   5. in_valid held low for TIMEOUT cycles after LEN -> err=1, mem_sel=0, no ram_wren seen.
//   6. Random in_valid gaps, plus rst asserted during WR of byte 2.
//      -> Wren drops immediately, state is IDLE, and a following good frame loads correctly.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the program loader: RAM geometry and the
// 4-bit loader state encoding.
package cpu_defs_pkg;

    localparam int RAM_AW = 8;
    localparam int DW     = 8;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_HALT = 4'd1;
    localparam logic [3:0] ST_LEN  = 4'd2;
    localparam logic [3:0] ST_DATA = 4'd3;
    localparam logic [3:0] ST_WR   = 4'd4;
    localparam logic [3:0] ST_SUM  = 4'd5;
    localparam logic [3:0] ST_RUN  = 4'd6;
    localparam logic [3:0] ST_DONE = 4'd7;
    localparam logic [3:0] ST_ERR  = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_HALT = ST_HALT,
        S_LEN  = ST_LEN,
        S_DATA = ST_DATA,
        S_WR   = ST_WR,
        S_SUM  = ST_SUM,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } ldr_state_e;

endpackage

// File: rtl/ldr_timer.sv
// Loadable down-counter used as the inter-byte idle timer.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   load_i          reload the counter with val_i (wins over dec_i)
//   dec_i           count one idle cycle
//   val_i           reload value
//   expire_o        this idle cycle is the last one allowed (terminal count)
module ldr_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = dec_i && (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/prog_loader.sv
// Program loader: halts the CPU, receives a LEN/data/SUM frame over a
// valid/ready byte stream, writes each data byte into program RAM and,
// on a matching checksum, releases the CPU.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   start_i             begin a load (only from IDLE/DONE/ERR)
//   in_valid_i/in_data_i/in_ready_o   byte stream
//   mem_sel_o           loader owns the RAM port
//   ram_addr_o/ram_data_o/ram_wren_o  RAM write port
//   cpu_halt_o/cpu_run_o              one-cycle CPU control pulses
//   busy_o, done_o, err_o             status (done/err sticky)
//
// state | meaning
// IDLE  | waiting for start after reset
// HALT  | one-cycle CPU halt pulse
// LEN   | waiting for length byte (0 = 256)
// DATA  | waiting for a data byte
// WR    | one-cycle RAM write of the latched byte
// SUM   | waiting for checksum byte
// RUN   | checksum good, one-cycle run pulse
// DONE  | last frame good
// ERR   | last frame bad or timed out
module prog_loader
    import cpu_defs_pkg::*;
#(
    parameter logic [RAM_AW-1:0] BASE_ADDR   = 8'h00,
    parameter bit                RUN_ON_DONE = 1'b1,
    parameter int                TIMEOUT     = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DW-1:0]     in_data_i,
    output logic              in_ready_o,
    output logic              mem_sel_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [DW-1:0]     ram_data_o,
    output logic              ram_wren_o,
    output logic              cpu_halt_o,
    output logic              cpu_run_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

    ldr_state_e        state_q;
    logic [8:0]        cnt_q;
    logic [RAM_AW-1:0] addr_q;
    logic [DW-1:0]     data_q;
    logic [DW-1:0]     sum_q;
    logic              in_ready_q;
    logic              mem_sel_q;
    logic              wren_q;
    logic              halt_q;
    logic              run_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic accept;
    logic waiting;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_expire;

    assign accept  = in_valid_i && in_ready_q;
    assign waiting = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_SUM);

    // Reload when a waiting state is entered and whenever a byte is taken.
    assign tmr_load = (state_q == S_HALT) || (state_q == S_WR) ||
                      (accept && ((state_q == S_LEN) || (state_q == S_DATA)));
    assign tmr_dec  = waiting && !accept;

    ldr_timer #(.W(8)) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (tmr_load),
        .dec_i    (tmr_dec),
        .val_i    (TO_VAL),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            mem_sel_q  <= 1'b0;
            wren_q     <= 1'b0;
            halt_q     <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q   <= S_HALT;
                        halt_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        mem_sel_q <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                S_HALT: begin
                    halt_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_LEN;
                end
                S_LEN: begin
                    if (accept) begin
                        cnt_q   <= (in_data_i == 8'h00) ? 9'd256 : {1'b0, in_data_i};
                        addr_q  <= BASE_ADDR;
                        sum_q   <= '0;
                        state_q <= S_DATA;
                    end else if (tmr_expire) begin
                        in_ready_q <= 1'b0;
                        mem_sel_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        data_q     <= in_data_i;
                        sum_q      <= sum_q + in_data_i;
                        in_ready_q <= 1'b0;
                        wren_q     <= 1'b1;
                        state_q    <= S_WR;
                    end else if (tmr_expire) begin
                        in_ready_q <= 1'b0;
                        mem_sel_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_WR: begin
                    // Address and data only move once the write cycle is over.
                    wren_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    addr_q     <= addr_q + 1'b1;
                    cnt_q      <= cnt_q - 1'b1;
                    state_q    <= (cnt_q == 9'd1) ? S_SUM : S_DATA;
                end
                S_SUM: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        mem_sel_q  <= 1'b0;
                        if (in_data_i == sum_q) begin
                            run_q   <= RUN_ON_DONE;
                            state_q <= S_RUN;
                        end else begin
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end else if (tmr_expire) begin
                        in_ready_q <= 1'b0;
                        mem_sel_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_RUN: begin
                    run_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    mem_sel_q  <= 1'b0;
                    wren_q     <= 1'b0;
                    halt_q     <= 1'b0;
                    run_q      <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign mem_sel_o  = mem_sel_q;
    assign ram_addr_o = addr_q;
    assign ram_data_o = data_q;
    assign ram_wren_o = wren_q;
    assign cpu_halt_o = halt_q;
    assign cpu_run_o  = run_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
